cache_ctrl: RTL and testbench

- Initiator/controller for the 16384-entry direct-mapped L1 tag cache (shared tri-state `data` bus, `found`, `we`, `oe`).
- Accepts lookup requests from the core side and runs the cache's lookup and read-back phases.
- On a miss, fetches from next-level memory through a valid/ack handshake, then issues the fill write (`we`=1) to the cache.
- Returns hit/miss/error per request and keeps saturating hit/miss statistics.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_stats.sv | 23 ++
 rtl/cache_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the L1 tag-cache controller.
package cache_pkg;
   localparam int ADDR_BITS = 32;
   localparam int INDEX_W   = 14;
   localparam int TAG_W     = ADDR_BITS - INDEX_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_READBACK,
      ST_MISS_REQ,
      ST_FILL,
      ST_RESP
   } ctrl_state_e;

   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_BITS-1:0] addr);
      return addr[ADDR_BITS-1:INDEX_W];
   endfunction

   function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_BITS-1:0] addr);
      return addr[INDEX_W-1:0];
   endfunction
endpackage

// File: rtl/cache_stats.sv
// Saturating hit/miss statistics counters.
module cache_stats #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_hit,
   input  logic             inc_miss,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (inc_hit && (hit_count != '1))
            hit_count <= hit_count + 1'b1;
         if (inc_miss && (miss_count != '1))
            miss_count <= miss_count + 1'b1;
      end
   end
endmodule

// File: rtl/cache_ctrl.sv
// Lookup/read-back/fill sequencer for the direct-mapped L1 tag cache.
// state    | meaning
// IDLE     | ready for a core request
// LOOKUP   | drive address on data, cache evaluates tag at negedge
// READBACK | oe=1, compare returned line against latched address
// MISS_REQ | fetch from next level, bounded by TIMEOUT
// FILL     | we=1, write tag/valid into the cache
// RESP     | hold response until the core accepts it
module cache_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 14,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic              resp_err,
   inout  wire  [ADDR_W-1:0] data,
   input  logic              found,
   output logic              we,
   output logic              oe,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   import cache_pkg::*;

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   ctrl_state_e       state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              hit_q, err_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              tmo_last, line_match, drive_bus, resp_fire;

   assign tmo_last   = (tmo_q == TMO_W'(TIMEOUT - 1));
   assign line_match = (tag_of(data) == tag_of(addr_q)) && (index_of(data) == index_of(addr_q));
   assign resp_fire  = (state == ST_RESP) && resp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (req_valid) state_nxt = ST_LOOKUP;
         ST_LOOKUP:   state_nxt = found ? ST_READBACK : ST_MISS_REQ;
         ST_READBACK: state_nxt = line_match ? ST_RESP : ST_MISS_REQ;
         ST_MISS_REQ: begin
            // a late ack still beats the timeout in the same cycle
            if (mem_ack)       state_nxt = ST_FILL;
            else if (tmo_last) state_nxt = ST_RESP;
         end
         ST_FILL:     state_nxt = ST_RESP;
         ST_RESP:     if (resp_ready) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      resp_hit   = (state == ST_RESP) && hit_q;
      resp_err   = (state == ST_RESP) && err_q;
      we         = (state == ST_FILL);
      oe         = (state == ST_READBACK);
      mem_valid  = (state == ST_MISS_REQ);
      mem_addr   = (state == ST_MISS_REQ) ? addr_q : '0;
      drive_bus  = (state == ST_LOOKUP) || (state == ST_FILL);
   end

   assign data = drive_bus ? addr_q : 'z;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         hit_q  <= 1'b0;
         err_q  <= 1'b0;
         tmo_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               addr_q <= req_addr;
               hit_q  <= 1'b0;
               err_q  <= 1'b0;
               tmo_q  <= '0;
            end
            ST_READBACK: hit_q <= line_match;
            ST_MISS_REQ: begin
               if (mem_ack) begin
                  tmo_q <= '0;
               end else if (tmo_last) begin
                  err_q <= 1'b1;
                  hit_q <= 1'b0;
                  tmo_q <= '0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_FILL: hit_q <= 1'b0;
            default: ;
         endcase
      end
   end

   cache_stats #(.CNT_W(CNT_W)) u_stats (
      .clk        (clk),
      .rst        (rst),
      .inc_hit    (resp_fire && hit_q),
      .inc_miss   (resp_fire && !hit_q),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural tag-cache and memory responder.
module tb_cache_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, resp_ready, mem_ack;
   logic [31:0] req_addr;
   logic        req_ready, resp_valid, resp_hit, resp_err, we, oe, mem_valid;
   logic [31:0] mem_addr;
   logic [15:0] hit_count, miss_count;
   wire  [31:0] data;
   logic        found;

   logic        req_valid2, resp_ready2, mem_ack2, found2;
   logic [31:0] req_addr2;
   logic        req_ready2, resp_valid2, resp_hit2, resp_err2, we2, oe2, mem_valid2;
   logic [31:0] mem_addr2;
   logic [1:0]  hit_count2, miss_count2;
   wire  [31:0] data2;

   int n_pass = 0, n_total = 0;
   int lat, mv, fill_cnt = 0;
   logic [31:0] fill_data, seen_mem_addr;
   logic        got_hit, got_err;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_err(resp_err),
      .data(data), .found(found), .we(we), .oe(oe), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count));

   cache_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
      .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_hit(resp_hit2), .resp_err(resp_err2),
      .data(data2), .found(found2), .we(we2), .oe(oe2), .mem_valid(mem_valid2), .mem_addr(mem_addr2),
      .mem_ack(mem_ack2), .hit_count(hit_count2), .miss_count(miss_count2));

   // behavioural tag cache: found registered on negedge, fill on posedge
   logic [17:0] tag_m [16384];
   logic        vld_m [16384];
   logic [13:0] idx_l;
   initial for (int i = 0; i < 16384; i++) begin vld_m[i] = 1'b0; tag_m[i] = '0; end

   always @(negedge clk) if (!oe) begin
      idx_l <= data[13:0];
      found <= vld_m[data[13:0]] && (tag_m[data[13:0]] == data[31:14]);
   end
   always @(posedge clk) if (we) begin
      vld_m[data[13:0]] = 1'b1;
      tag_m[data[13:0]] = data[31:14];
      fill_cnt++;
      fill_data = data;
   end
   assign data  = oe  ? {tag_m[idx_l], idx_l} : 32'bz;
   assign data2 = oe2 ? 32'h0000_1234 : 32'bz;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // issue one request; ack_dly=0 means memory never answers; hold = cycles resp_ready stays low
   task automatic run_req(input logic [31:0] addr, input int ack_dly, input int hold);
      int w;
      w = 0;
      while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
      chk("req_ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1; req_addr = addr;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; mv = 0; seen_mem_addr = '0;
      while (!resp_valid && lat < 300) begin
         if (mem_valid) begin mv++; seen_mem_addr = mem_addr; end
         mem_ack = (ack_dly > 0) && mem_valid && (mv == ack_dly);
         @(posedge clk); #1;
         lat++;
      end
      mem_ack = 1'b0;
      chk("resp_valid_seen", resp_valid, 1'b1);
      got_hit = resp_hit; got_err = resp_err;
      for (int i = 0; i < hold; i++) begin
         chk("hold_resp_valid", resp_valid, 1'b1);
         chk("hold_resp_hit", resp_hit, got_hit);
         chk("hold_req_ready", req_ready, 1'b0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("idle_after_resp", req_ready, 1'b1);
   endtask

   initial begin
      int w, f0;
      rst = 1'b1; req_valid = 0; resp_ready = 0; mem_ack = 0; req_addr = '0;
      req_valid2 = 0; resp_ready2 = 0; mem_ack2 = 0; found2 = 1'b1; req_addr2 = '0;
      #23;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_we_oe", {we, oe}, 2'b00);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_counts", {hit_count, miss_count}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // cold miss, ack 3 cycles after mem_valid
      run_req(32'h0000_1234, 3, 0);
      chk("cold_lat", lat, 5);
      chk("cold_mem_addr", seen_mem_addr, 32'h0000_1234);
      chk("cold_fill_cnt", fill_cnt, 1);
      chk("cold_fill_data", fill_data, 32'h0000_1234);
      chk("cold_hit_err", {got_hit, got_err}, 2'b00);
      chk("cold_miss_count", miss_count, 16'd1);

      // repeat: hit, resp 2 cycles after accept
      run_req(32'h0000_1234, 3, 0);
      chk("hit_lat", lat, 2);
      chk("hit_flags", {got_hit, got_err}, 2'b10);
      chk("hit_count1", hit_count, 16'd1);
      chk("hit_no_fill", fill_cnt, 1);

      // conflict on same index, then original address misses again
      run_req(32'h0004_1234, 2, 0);
      chk("conf_flags", {got_hit, got_err}, 2'b00);
      chk("conf_fill_data", fill_data, 32'h0004_1234);
      chk("conf_miss_count", miss_count, 16'd2);
      run_req(32'h0000_1234, 1, 0);
      chk("evicted_flags", {got_hit, got_err}, 2'b00);
      chk("evicted_fill_cnt", fill_cnt, 3);
      chk("evicted_miss_count", miss_count, 16'd3);

      // memory never acks
      run_req(32'h0000_5678, 0, 0);
      chk("tmo_flags", {got_hit, got_err}, 2'b01);
      chk("tmo_mv_cycles", mv, 64);
      chk("tmo_lat", lat, 65);
      chk("tmo_no_fill", fill_cnt, 3);
      chk("tmo_miss_count", miss_count, 16'd4);

      // hit with core back-pressure
      run_req(32'h0000_1234, 1, 5);
      chk("bp_flags", {got_hit, got_err}, 2'b10);
      chk("bp_hit_count", hit_count, 16'd2);
      chk("bp_miss_count", miss_count, 16'd4);

      // async reset in the middle of a miss
      req_valid = 1'b1; req_addr = 32'h0000_9abc;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1; @(posedge clk); #1;
      chk("abort_in_miss", mem_valid, 1'b1);
      f0 = fill_cnt;
      #3 rst = 1'b1;
      #1;
      chk("abort_mem_valid", mem_valid, 1'b0);
      chk("abort_we_oe", {we, oe}, 2'b00);
      chk("abort_counts", {hit_count, miss_count}, 32'h0);
      chk("abort_req_ready", req_ready, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      chk("abort_no_fill", fill_cnt, f0);
      chk("abort_no_resp", resp_valid, 1'b0);
      run_req(32'h0000_1234, 1, 0);
      chk("post_rst_flags", {got_hit, got_err}, 2'b10);
      chk("post_rst_counts", {hit_count, miss_count}, {16'd1, 16'd0});

      // narrow counters saturate
      for (int k = 0; k < 5; k++) begin
         req_valid2 = 1'b1; req_addr2 = 32'h0000_1234;
         @(posedge clk); #1 req_valid2 = 1'b0;
         w = 0;
         while (!resp_valid2 && w < 20) begin @(posedge clk); #1; w++; end
         chk("sat_resp_hit", {resp_valid2, resp_hit2}, 2'b11);
         resp_ready2 = 1'b1;
         @(posedge clk); #1 resp_ready2 = 1'b0;
         @(posedge clk); #1;
      end
      chk("sat_hit_count", hit_count2, 2'd3);
      chk("sat_miss_count", miss_count2, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
